alu_issue: RTL and testbench
============================

// Module: alu_issue
// PURPOSE
// Decode/issue stage that feeds the ALU. Accepts one 32-bit MIPS instruction per handshake, reads
// rs/rt from the register file, and registers ALU-ready operands (a, b, shamt, alu_op) plus
// destination info into a single-entry pipeline register with valid/ready flow control toward EX.
// PARAMETERS
// CNT_W  16  width of the saturating issued-instruction counter
// PORTS
// clk         in   1      clock, all state on rising edge
// rst         in   1      asynchronous reset, active-high
// in_valid    in   1      in_instr is valid
// in_ready    out  1      stage can accept in_instr this cycle
// in_instr    in   32     instruction word
// rs_addr     out  5      regfile read addr = in_instr[25:21] (combinational)
// rt_addr     out  5      regfile read addr = in_instr[20:16] (combinational)
// rs_data     in   32     regfile read data for rs_addr, same cycle
// rt_data     in   32     regfile read data for rt_addr, same cycle
// out_valid   out  1      EX bundle valid
// out_ready   in   1      EX consumes bundle when out_valid && out_ready
// out_a       out  32     ALU operand a
// out_b       out  32     ALU operand b
// out_shamt   out  5      ALU shift amount
// out_alu_op  out  6      ALU function code
// out_rd      out  5      destination register
// out_we      out  1      write-back enable
// out_illegal out  1      instruction not supported by this stage
// err_sticky  out  1      set on any accepted illegal instruction, cleared only by rst
// issued_cnt  out  CNT_W  count of accepted instructions, saturates at all-ones
// BEHAVIOUR
// - Reset (async, rst=1): out_valid=0, all out_* data=0, err_sticky=0, issued_cnt=0.
// - in_ready = !out_valid || out_ready (combinational; no skid). Accept = in_valid && in_ready.
// - On accept: out register loads decode of in_instr/rs_data/rt_data, out_valid=1; latency 1 cycle.
// - out_valid && out_ready && !in_valid: out_valid->0. Simultaneous consume+accept: new bundle
//   replaces old, out_valid stays 1. While out_valid && !out_ready: all out_* held stable.
// - R-type (op=0x00), alu_op=funct, out_rd=rd:
//   sll/srl/sra (0x00/02/03): a=rt_data, b=0, shamt=instr[10:6].
//   sllv/srlv/srav (0x04/06/07): a={27'b0,rs_data[4:0]}, b=rt_data, shamt=0.
//   add/addu/sub/subu/and/or/xor/nor/slt/sltu (0x20-0x27,0x2a,0x2b): a=rs_data, b=rt_data, shamt=0.
// - I-type, out_rd=rt, a=rs_data, shamt=0:
//   addi 0x08->0x20, addiu 0x09->0x21, slti 0x0a->0x2a, sltiu 0x0b->0x2b: b=sign-ext imm16.
//   andi 0x0c->0x24, ori 0x0d->0x25, xori 0x0e->0x26: b=zero-ext imm16.
//   lui 0x0f->alu_op 0x00, a={16'b0,imm16}, b=0, shamt=16.
// - out_we = !illegal && (out_rd != 0).
// - Any other opcode/funct: out_illegal=1, out_we=0, alu_op=0x21, a=b=0, shamt=0, out_rd=0;
//   still issued as a valid bundle (EX raises the exception); err_sticky<=1.
// - issued_cnt increments on each accept, holds at 2^CNT_W-1.
// - Reset mid-stall drops the held bundle; first accept after reset is the next handshake.
// TESTING
// add $3,$1,$2 (0x00221820), rs=5, rt=7 -> next cycle out_valid=1, a=5, b=7, op=0x20, rd=3, we=1.
// sll $2,$1,4 (0x00011100), rt=0x1 -> a=1, shamt=4, op=0x00, rd=2; sllv 0x00221804, rs=0x25
//   -> a=5, b=rt_data, op=0x04, rd=3.
// lui $5,0x1234 (0x3C051234) -> a=0x1234, shamt=16, op=0x00, rd=5; addi $4,$0,-1 (0x2004FFFF)
//   -> b=0xFFFFFFFF, op=0x20; andi $4,$1,0xFFFF (0x3024FFFF) -> b=0x0000FFFF, op=0x24.
// Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, issued_cnt unchanged;
//   out_ready=1 -> consume+accept same cycle, out_valid stays 1.
// Opcode 0x3F -> out_illegal=1, we=0, err_sticky=1 persists; addu $0,$1,$2 -> we=0; rst mid-stall
//   -> out_valid=0, err_sticky=0, issued_cnt=0 immediately.
// CNT_W=2: 5 accepts -> issued_cnt=3.

Source files
------------

// File: rtl/alu_issue.sv
// Decode/issue stage ahead of the ALU: decodes one MIPS instruction per handshake into
// ALU-ready operands and holds them in a single-entry valid/ready pipeline register.
module alu_issue #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   output logic [4:0]       rs_addr,
   output logic [4:0]       rt_addr,
   input  logic [31:0]      rs_data,
   input  logic [31:0]      rt_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_a,
   output logic [31:0]      out_b,
   output logic [4:0]       out_shamt,
   output logic [5:0]       out_alu_op,
   output logic [4:0]       out_rd,
   output logic             out_we,
   output logic             out_illegal,
   output logic             err_sticky,
   output logic [CNT_W-1:0] issued_cnt
);

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  shamt;
      logic [5:0]  alu_op;
      logic [4:0]  rd;
      logic        we;
      logic        illegal;
   } bundle_t;

   logic [5:0]       w_op;
   logic [5:0]       w_funct;
   logic [15:0]      w_imm;
   logic [31:0]      w_simm;
   logic [31:0]      w_zimm;
   logic             w_legal;
   logic             w_accept;
   bundle_t          w_dec;

   logic             r_valid;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt;
   bundle_t          r_out;

   assign w_op     = in_instr[31:26];
   assign w_funct  = in_instr[5:0];
   assign w_imm    = in_instr[15:0];
   assign w_simm   = {{16{w_imm[15]}}, w_imm};
   assign w_zimm   = {16'h0000, w_imm};

   assign rs_addr  = in_instr[25:21];
   assign rt_addr  = in_instr[20:16];
   assign in_ready = !r_valid || out_ready;
   assign w_accept = in_valid && in_ready;

   // NOTE: every field gets a default before the case so no path leaves a latch behind.
   always_comb begin
      w_dec    = '0;
      w_legal  = 1'b1;
      w_dec.rd = in_instr[20:16];
      w_dec.a  = rs_data;
      case (w_op)
         6'h00: begin
            w_dec.rd     = in_instr[15:11];
            w_dec.alu_op = w_funct;
            case (w_funct)
               6'h00, 6'h02, 6'h03: begin
                  w_dec.a     = rt_data;
                  w_dec.shamt = in_instr[10:6];
               end
               6'h04, 6'h06, 6'h07: begin
                  w_dec.a = {27'b0, rs_data[4:0]};
                  w_dec.b = rt_data;
               end
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: begin
                  w_dec.b = rt_data;
               end
               default: w_legal = 1'b0;
            endcase
         end
         6'h08: begin w_dec.alu_op = 6'h20; w_dec.b = w_simm; end
         6'h09: begin w_dec.alu_op = 6'h21; w_dec.b = w_simm; end
         6'h0a: begin w_dec.alu_op = 6'h2a; w_dec.b = w_simm; end
         6'h0b: begin w_dec.alu_op = 6'h2b; w_dec.b = w_simm; end
         6'h0c: begin w_dec.alu_op = 6'h24; w_dec.b = w_zimm; end
         6'h0d: begin w_dec.alu_op = 6'h25; w_dec.b = w_zimm; end
         6'h0e: begin w_dec.alu_op = 6'h26; w_dec.b = w_zimm; end
         6'h0f: begin
            w_dec.a     = w_zimm;
            w_dec.shamt = 5'd16;
         end
         default: w_legal = 1'b0;
      endcase
      // Unsupported encodings still travel to EX, flagged, so it can raise the exception.
      if (!w_legal) begin
         w_dec         = '0;
         w_dec.alu_op  = 6'h21;
         w_dec.illegal = 1'b1;
      end
      w_dec.we = w_legal && (w_dec.rd != 5'd0);
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_out   <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         if (w_accept) begin
            r_out   <= w_dec;
            r_valid <= 1'b1;
            r_err   <= r_err | w_dec.illegal;
            if (r_cnt != '1)
               r_cnt <= r_cnt + CNT_W'(1);
         end else if (out_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign out_valid   = r_valid;
   assign out_a       = r_out.a;
   assign out_b       = r_out.b;
   assign out_shamt   = r_out.shamt;
   assign out_alu_op  = r_out.alu_op;
   assign out_rd      = r_out.rd;
   assign out_we      = r_out.we;
   assign out_illegal = r_out.illegal;
   assign err_sticky  = r_err;
   assign issued_cnt  = r_cnt;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed literal checks plus random traffic
// compared every cycle against a behavioural model of the issue stage.
module tb_alu_issue;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  shamt;
      logic [5:0]  alu_op;
      logic [4:0]  rd;
      logic        we;
      logic        illegal;
   } bnd_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, out_we, out_illegal, err_sticky;
   logic [4:0]  rs_addr, rt_addr, out_shamt, out_rd;
   logic [31:0] out_a, out_b;
   logic [5:0]  out_alu_op;
   logic [15:0] issued_cnt;

   logic        s_in_ready, s_out_valid, s_out_we, s_out_illegal, s_err_sticky;
   logic [4:0]  s_rs_addr, s_rt_addr, s_out_shamt, s_out_rd;
   logic [31:0] s_out_a, s_out_b;
   logic [5:0]  s_out_alu_op;
   logic [1:0]  s_issued_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   alu_issue #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
      .out_shamt(out_shamt), .out_alu_op(out_alu_op), .out_rd(out_rd), .out_we(out_we),
      .out_illegal(out_illegal), .err_sticky(err_sticky), .issued_cnt(issued_cnt)
   );

   alu_issue #(.CNT_W(2)) dut_small (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr),
      .rs_addr(s_rs_addr), .rt_addr(s_rt_addr), .rs_data(rs_data), .rt_data(rt_data),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_a(s_out_a), .out_b(s_out_b),
      .out_shamt(s_out_shamt), .out_alu_op(s_out_alu_op), .out_rd(s_out_rd), .out_we(s_out_we),
      .out_illegal(s_out_illegal), .err_sticky(s_err_sticky), .issued_cnt(s_issued_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode written directly from the instruction-set rules.
   function automatic bnd_t ref_decode(input logic [31:0] ins, input logic [31:0] rsd,
                                       input logic [31:0] rtd);
      bnd_t r;
      int   op, fn;
      logic [15:0] imm;
      bit   ok;
      op  = int'(ins[31:26]);
      fn  = int'(ins[5:0]);
      imm = ins[15:0];
      r   = '0;
      ok  = 1'b1;
      if (op == 0) begin
         r.rd     = ins[15:11];
         r.alu_op = 6'(fn);
         if (fn inside {0, 2, 3}) begin
            r.a = rtd; r.shamt = ins[10:6];
         end else if (fn inside {4, 6, 7}) begin
            r.a = rsd % 32; r.b = rtd;
         end else if (fn inside {[32:39], 42, 43}) begin
            r.a = rsd; r.b = rtd;
         end else ok = 1'b0;
      end else if (op inside {[8:14]}) begin
         r.rd     = ins[20:16];
         r.a      = rsd;
         r.alu_op = (op == 10 || op == 11) ? 6'(32 + op) : 6'(24 + op);
         r.b      = (op < 12) ? 32'(int'($signed(imm))) : 32'(int'(imm));
      end else if (op == 15) begin
         r.rd = ins[20:16]; r.a = 32'(int'(imm)); r.shamt = 5'd16;
      end else ok = 1'b0;
      if (!ok) begin
         r = '0; r.alu_op = 6'h21; r.illegal = 1'b1;
      end
      r.we = ok && (r.rd != 0);
      return r;
   endfunction

   // Model state: one held bundle, its valid flag, counters and sticky error.
   bnd_t m_b;
   bit   m_valid;
   bit   m_err;
   int   m_cnt, m_cnt2;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid = 0; m_b = '0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
      end else if (in_valid && (!m_valid || out_ready)) begin
         m_b     = ref_decode(in_instr, rs_data, rt_data);
         m_valid = 1;
         m_err   = m_err || m_b.illegal;
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt2 < 3) m_cnt2++;
      end else if (out_ready) begin
         m_valid = 0;
      end
   end

   always @(negedge clk) begin
      check("in_ready",   32'(in_ready),   32'(!m_valid || out_ready));
      check("rs_addr",    32'(rs_addr),    32'(in_instr[25:21]));
      check("rt_addr",    32'(rt_addr),    32'(in_instr[20:16]));
      check("out_valid",  32'(out_valid),  32'(m_valid));
      check("out_a",      out_a,           m_b.a);
      check("out_b",      out_b,           m_b.b);
      check("out_shamt",  32'(out_shamt),  32'(m_b.shamt));
      check("out_alu_op", 32'(out_alu_op), 32'(m_b.alu_op));
      check("out_rd",     32'(out_rd),     32'(m_b.rd));
      check("out_we",     32'(out_we),     32'(m_b.we));
      check("illegal",    32'(out_illegal), 32'(m_b.illegal));
      check("err_sticky", 32'(err_sticky), 32'(m_err));
      check("issued_cnt", 32'(issued_cnt), 32'(m_cnt));
      check("cnt_small",  32'(s_issued_cnt), 32'(m_cnt2));
   end

   task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] rsd,
                      input logic [31:0] rtd, input bit ordy);
      in_valid = v; in_instr = ins; rs_data = rsd; rt_data = rtd; out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      int rfun[13] = '{0, 2, 3, 4, 6, 7, 32, 33, 34, 35, 36, 38, 43};
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 3))
         0: ;
         1: w = {6'h00, w[25:6], 6'(rfun[$urandom_range(0, 12)])};
         2: w = {6'(8 + $urandom_range(0, 7)), w[25:0]};
         default: w = {6'h00, w[25:0]};
      endcase
      return w;
   endfunction

   initial begin
      @(posedge clk); @(posedge clk); #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_cnt",   32'(issued_cnt), 32'd0);
      check("rst_err",   32'(err_sticky), 32'd0);
      rst = 1'b0;

      cyc(1, 32'h00221820, 32'd5, 32'd7, 1);   // add $3,$1,$2
      check("add_valid", 32'(out_valid), 32'd1);
      check("add_a", out_a, 32'd5);
      check("add_b", out_b, 32'd7);
      check("add_op", 32'(out_alu_op), 32'h20);
      check("add_rd", 32'(out_rd), 32'd3);
      check("add_we", 32'(out_we), 32'd1);

      cyc(1, 32'h00011100, 32'h0, 32'h1, 1);   // sll $2,$1,4
      check("sll_a", out_a, 32'd1);
      check("sll_shamt", 32'(out_shamt), 32'd4);
      check("sll_op", 32'(out_alu_op), 32'h00);
      check("sll_rd", 32'(out_rd), 32'd2);

      cyc(1, 32'h00221804, 32'h25, 32'hABCD0123, 1);   // sllv
      check("sllv_a", out_a, 32'd5);
      check("sllv_b", out_b, 32'hABCD0123);
      check("sllv_op", 32'(out_alu_op), 32'h04);
      check("sllv_rd", 32'(out_rd), 32'd3);

      cyc(1, 32'h3C051234, 32'h99, 32'h77, 1);   // lui $5,0x1234
      check("lui_a", out_a, 32'h1234);
      check("lui_b", out_b, 32'h0);
      check("lui_shamt", 32'(out_shamt), 32'd16);
      check("lui_rd", 32'(out_rd), 32'd5);

      cyc(1, 32'h2004FFFF, 32'h0, 32'h0, 1);   // addi $4,$0,-1
      check("addi_b", out_b, 32'hFFFFFFFF);
      check("addi_op", 32'(out_alu_op), 32'h20);

      cyc(1, 32'h3024FFFF, 32'h3, 32'h0, 1);   // andi $4,$1,0xFFFF
      check("andi_b", out_b, 32'h0000FFFF);
      check("andi_op", 32'(out_alu_op), 32'h24);

      for (int i = 0; i < 3; i++) begin
         cyc(1, 32'h3825000F, 32'h10, 32'h0, 0);   // xori waits behind a stalled andi
         check("stall_ready", 32'(in_ready), 32'd0);
         check("stall_b", out_b, 32'h0000FFFF);
         check("stall_op", 32'(out_alu_op), 32'h24);
         check("stall_cnt", 32'(issued_cnt), 32'd6);
      end
      cyc(1, 32'h3825000F, 32'h10, 32'h0, 1);
      check("xori_valid", 32'(out_valid), 32'd1);
      check("xori_a", out_a, 32'h10);
      check("xori_b", out_b, 32'hF);
      check("xori_op", 32'(out_alu_op), 32'h26);
      check("xori_cnt", 32'(issued_cnt), 32'd7);

      cyc(1, 32'hFC000000, 32'h1, 32'h2, 1);   // opcode 0x3F
      check("ill_flag", 32'(out_illegal), 32'd1);
      check("ill_we", 32'(out_we), 32'd0);
      check("ill_op", 32'(out_alu_op), 32'h21);
      check("ill_err", 32'(err_sticky), 32'd1);

      cyc(1, 32'h00220021, 32'h1, 32'h2, 1);   // addu $0,$1,$2
      check("r0_we", 32'(out_we), 32'd0);
      check("r0_illegal", 32'(out_illegal), 32'd0);
      check("r0_err", 32'(err_sticky), 32'd1);

      cyc(0, 32'h0, 32'h0, 32'h0, 1);
      check("drain_valid", 32'(out_valid), 32'd0);

      cyc(1, 32'h00221820, 32'd5, 32'd7, 0);
      cyc(1, 32'h00221820, 32'd5, 32'd7, 0);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_valid", 32'(out_valid), 32'd0);
      check("rst_mid_err",   32'(err_sticky), 32'd0);
      check("rst_mid_cnt",   32'(issued_cnt), 32'd0);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) cyc(1, 32'h00221820, 32'd5, 32'd7, 1);
      check("sat_small", 32'(s_issued_cnt), 32'd3);
      check("sat_big",   32'(issued_cnt), 32'd5);

      for (int i = 0; i < 400; i++)
         cyc(($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom,
             ($urandom_range(0, 2) != 0));

      cyc(0, 32'h0, 32'h0, 32'h0, 1);
      @(negedge clk); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
